fact_ctrl: RTL and testbench
============================

Name: fact_ctrl

Overview:
Memory-mapped initiator that drives the factorial engine's go/done/err/nf handshake from the CPU data bus.
- Software writes n, then writes a start command; the block pulses go and waits for done or err.
- Result and status are latched in registers the CPU reads.
- Sits between the MIPS data-memory decoder (peripheral select) and one factorial engine instance.

Parameters:
WIDTH, 32, data width of n, result and bus data
TIMEOUT, 1024, cycles to wait for engine done/err before declaring a timeout error (must be >= 2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
sel  input  1  peripheral select from address decoder
we  input  1  write enable, qualified by sel
addr  input  2  word index: 0=N, 1=CTRL, 2=STATUS, 3=RESULT
wd  input  WIDTH  write data
rd  output  WIDTH  read data, combinational from addr
eng_n  output  WIDTH  operand to engine; held stable while busy
eng_go  output  1  start pulse to engine
eng_done  input  1  engine completion
eng_err  input  1  engine input-range or overflow error
eng_nf  input  WIDTH  engine result, valid while eng_done=1
irq  output  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset (rst=0, async): N=0, RESULT=0, all status bits 0, eng_go=0, irq=0, state=IDLE, timeout counter=0.
- Registers:
  - N (RW).
  - CTRL (WO; bit0=start, bit1=clear, bit2=ie; reads 0 except bit2).
  - STATUS (RO; bit0=busy, bit1=done, bit2=err, bit3=timeout, bit4=ovr).
  - RESULT (RO).
- Write strobe: sel&we, sampled at posedge clk. rd returns 0 when addr is out of range or unused bits are read.
- FSM states: IDLE, START, WAIT.
  - IDLE: start=1 written → latch N into eng_n; clear done/err/timeout/RESULT; go to START.
  - START: eng_go=1 for exactly this one cycle; timeout counter=0; go to WAIT.
  - WAIT: eng_go=0; counter increments each cycle.
    - First cycle with eng_done=1: RESULT<=eng_nf, done<=1, err<=eng_err, go to IDLE.
    - eng_err=1 without done: err<=1, RESULT unchanged (0), go to IDLE.
    - Counter reaches TIMEOUT-1 with neither: timeout<=1, err<=1, go to IDLE.
    - Completion has priority over timeout in the same cycle.
- busy=1 in START and WAIT.
- Latency: start write at cycle T → eng_go high at T+1 → WAIT from T+2. If the engine completes at cycle C, STATUS.done is visible at C+1.
- Write to N while busy: ignored; ovr<=1.
- start while busy: ignored; ovr<=1.
- clear=1: clears done, err, timeout and ovr. This is permitted while busy but does not abort the FSM.
  - clear and start in the same write: clear is applied first, then start proceeds (IDLE only).
- done/err/timeout are sticky until the next accepted start or a clear.
- Reset mid-WAIT: everything returns to reset values. The engine is reset by the same rst, so no stale done is accepted.

Optional Feature:
FACT_CTRL_IRQ_EN
- Defined: irq = ie & (done | err), a level output cleared by a clear write or the next start. ie is stored in CTRL bit2 and reads back.
- Undefined: irq is tied to 0, ie is not stored, and CTRL bit2 reads 0.

Decomposition:
- Package fact_pkg holds:
  - register index localparams (FACT_N, FACT_CTRL, FACT_STATUS, FACT_RESULT);
  - CTRL and STATUS bit-position localparams;
  - the state enum typedef fact_ctrl_state_t (IDLE, START, WAIT).
- One sub-module is natural: fact_wdog, a clearable up-counter with terminal-count flag at TIMEOUT-1, used for the WAIT timeout.

Test Plan:
- Nominal run: write N=5, write CTRL=1; behavioural engine asserts done 6 cycles after go with nf=120 → eng_go is high for exactly 1 cycle; busy=1 until done; STATUS=0x02; RESULT=120.
- Engine error: N=13, engine model asserts err (overflow) → STATUS=0x06; RESULT=0; busy=0.
- Timeout: TIMEOUT=16, engine model never responds → STATUS=0x0C exactly 16 cycles after entering WAIT.
- Overrun while busy: during WAIT, write N=7 and CTRL=1 → eng_n unchanged at 5; ovr=1; no second eng_go. A later CTRL=2 clears STATUS to 0.
- Reset mid-operation: assert rst=0 two cycles into WAIT → rd(STATUS)=0, RESULT=0, eng_go=0 immediately (asynchronous). A new start after release completes normally.
- With FACT_CTRL_IRQ_EN defined: CTRL=0x5 with N=3 → irq rises 1 cycle after engine done (nf=6); CTRL=0x2 drops irq.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state type for the
// factorial-engine initiator.
package fact_pkg;

  localparam logic [1:0] FACT_N      = 2'd0;
  localparam logic [1:0] FACT_CTRL   = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_IE    = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_OVR     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } fact_ctrl_state_t;

endpackage

// File: rtl/fact_wdog.sv
// Clearable up-counter that raises tc once it reaches TIMEOUT-1 and then
// holds there until cleared.
module fact_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fact_ctrl.sv
// Memory-mapped initiator for one factorial engine: N/CTRL/STATUS/RESULT
// registers plus the go/done/err handshake. Build with FACT_CTRL_IRQ_EN to get irq.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] eng_n,
  output logic             eng_go,
  input  logic             eng_done,
  input  logic             eng_err,
  input  logic [WIDTH-1:0] eng_nf,
  output logic             irq,
  output fact_ctrl_state_t dbg_state
);

  // Handshake: eng_go is a single-cycle request with eng_n stable until the
  // FSM is back in IDLE. The first WAIT cycle with eng_done=1 (eng_nf valid,
  // eng_err qualifying it) or eng_err=1 alone is consumed; there is no
  // backpressure on either side.

  fact_ctrl_state_t state, state_d;

  logic [WIDTH-1:0] n_q, result_q;
  logic done_q, err_q, to_q, ovr_q;
  logic wr_n, wr_ctrl, start_cmd, clear_cmd, busy, ovr_set;
  logic accept_start, wd_clr, wd_en, wd_tc;
  logic fin_done, fin_err, fin_to;

  assign wr_n      = sel && we && (addr == FACT_N);
  assign wr_ctrl   = sel && we && (addr == FACT_CTRL);
  assign start_cmd = wr_ctrl && wd[CTRL_START];
  assign clear_cmd = wr_ctrl && wd[CTRL_CLEAR];
  assign busy      = (state != IDLE);
  assign ovr_set   = busy && (wr_n || start_cmd);
  assign dbg_state = state;

  fact_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .en  (wd_en),
    .tc  (wd_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d      = state;
    eng_go       = 1'b0;
    accept_start = 1'b0;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    fin_done     = 1'b0;
    fin_err      = 1'b0;
    fin_to       = 1'b0;
    case (state)
      IDLE: begin
        if (start_cmd) begin
          accept_start = 1'b1;
          state_d      = START;
        end
      end
      START: begin
        eng_go  = 1'b1;
        wd_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        // Completion outranks the timeout terminal count in the same cycle.
        if (eng_done) begin
          fin_done = 1'b1;
          state_d  = IDLE;
        end else if (eng_err) begin
          fin_err = 1'b1;
          state_d = IDLE;
        end else if (wd_tc) begin
          fin_to  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q      <= '0;
      eng_n    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_n && !busy) n_q <= wd;
      // Clear lands before start so a combined write still launches cleanly.
      if (clear_cmd) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        to_q   <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (accept_start) begin
        eng_n    <= n_q;
        result_q <= '0;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        to_q     <= 1'b0;
      end
      if (ovr_set) ovr_q <= 1'b1;
      if (fin_done) begin
        result_q <= eng_nf;
        done_q   <= 1'b1;
        err_q    <= eng_err;
      end
      if (fin_err) err_q <= 1'b1;
      if (fin_to) begin
        to_q  <= 1'b1;
        err_q <= 1'b1;
      end
    end
  end

`ifdef FACT_CTRL_IRQ_EN
  logic ie_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ie_q <= 1'b0;
    else if (wr_ctrl) ie_q <= wd[CTRL_IE];
  end

  assign irq = ie_q && (done_q || err_q);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (addr)
      FACT_N: rd = n_q;
      FACT_CTRL: begin
`ifdef FACT_CTRL_IRQ_EN
        rd[CTRL_IE] = ie_q;
`endif
      end
      FACT_STATUS: begin
        rd[STAT_BUSY]    = busy;
        rd[STAT_DONE]    = done_q;
        rd[STAT_ERR]     = err_q;
        rd[STAT_TIMEOUT] = to_q;
        rd[STAT_OVR]     = ovr_q;
      end
      FACT_RESULT: rd = result_q;
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Randomized self-checking bench for fact_ctrl with a behavioural factorial
// engine; irq checks follow FACT_CTRL_IRQ_EN.
module tb_fact_ctrl;
  import fact_pkg::*;

  localparam int W  = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0, we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [W-1:0] wd = '0;
  logic [W-1:0] rd, eng_n, eng_nf;
  logic eng_go, eng_done, eng_err, irq;
  fact_ctrl_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int go_cnt = 0;
  int eng_mode = 0;  // 0: done (err if overflow), 1: err only, 2: silent
  int eng_lat  = 1;

  fact_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .eng_n(eng_n), .eng_go(eng_go), .eng_done(eng_done), .eng_err(eng_err),
    .eng_nf(eng_nf), .irq(irq), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fact_ref(input logic [31:0] n);
    logic [63:0] f = 64'd1;
    for (int i = 2; i <= 20; i++) if (i <= n) f = f * 64'(i);
    return f;
  endfunction

  // Go pulses observed mid-cycle; one transaction must add exactly one.
  always @(negedge clk) if (eng_go === 1'b1) go_cnt++;

  task automatic engine_respond();
    logic [63:0] f;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < eng_lat; i++) begin
      @(negedge clk);
      if (!rst) ok = 1'b0;
    end
    if (ok && rst) begin
      f = fact_ref(eng_n);
      eng_done = (eng_mode == 0);
      eng_err  = (eng_mode == 1) || (f > 64'hFFFF_FFFF);
      eng_nf   = (eng_mode == 0 && f <= 64'hFFFF_FFFF) ? f[31:0] : '0;
      @(negedge clk);
      eng_done = 1'b0;
      eng_err  = 1'b0;
      eng_nf   = '0;
    end
  endtask

  initial begin
    eng_done = 1'b0;
    eng_err  = 1'b0;
    eng_nf   = '0;
    forever begin
      @(negedge clk);
      if (rst && eng_go === 1'b1 && eng_mode != 2) engine_respond();
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rd;
  endtask

  // Full transaction: busy exactly through the response cycle, then final status.
  task automatic run_txn(input logic [31:0] n, input int mode, input int lat,
                         input logic [31:0] ctrl_word);
    logic [31:0] st, res, exp_st, exp_res;
    logic [63:0] f;
    int g0, l;
    f = fact_ref(n);
    l = (mode == 2) ? TO : lat;
    if (mode == 2)                 begin exp_st = 32'h0C; exp_res = 0; end
    else if (mode == 1)            begin exp_st = 32'h04; exp_res = 0; end
    else if (f > 64'hFFFF_FFFF)    begin exp_st = 32'h06; exp_res = 0; end
    else                           begin exp_st = 32'h02; exp_res = f[31:0]; end
    eng_mode = mode;
    eng_lat  = lat;
    bus_write(FACT_N, n);
    g0 = go_cnt;
    bus_write(FACT_CTRL, ctrl_word);
    repeat (l) @(negedge clk);
    bus_read(FACT_STATUS, st);
    check("status_busy", st, 32'h01);
    check("irq_busy", {31'd0, irq}, 32'd0);
    @(negedge clk);
    bus_read(FACT_STATUS, st);
    check("status_final", st, exp_st);
    bus_read(FACT_RESULT, res);
    check("result", res, exp_res);
    check("go_pulses", 32'(go_cnt - g0), 32'd1);
    check("eng_n", eng_n, n);
`ifdef FACT_CTRL_IRQ_EN
    check("irq_final", {31'd0, irq}, {31'd0, ctrl_word[CTRL_IE]});
`else
    check("irq_final", {31'd0, irq}, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] v;
    int g0;

    // Reset values
    repeat (3) @(negedge clk);
    bus_read(FACT_N, v);       check("rst_n", v, 0);
    bus_read(FACT_STATUS, v);  check("rst_status", v, 0);
    bus_read(FACT_RESULT, v);  check("rst_result", v, 0);
    check("rst_go", {31'd0, eng_go}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    bus_write(FACT_N, 32'h0000_ABCD);
    bus_read(FACT_N, v);       check("n_readback", v, 32'h0000_ABCD);
    bus_write(FACT_CTRL, 32'h4);
    bus_read(FACT_CTRL, v);
`ifdef FACT_CTRL_IRQ_EN
    check("ctrl_ie_read", v, 32'h4);
`else
    check("ctrl_ie_read", v, 32'h0);
`endif
    bus_write(FACT_CTRL, 32'h0);

    // Directed: nominal, overflow, timeout, completion at terminal count, err only
    run_txn(5, 0, 6, 1);
    run_txn(13, 0, 6, 1);
    run_txn(3, 2, 0, 1);
    run_txn(7, 0, TO, 1);
    run_txn(2, 1, 4, 1);
    run_txn(3, 0, 5, 5);
    bus_write(FACT_CTRL, 32'h2);
    check("irq_cleared", {31'd0, irq}, 0);
    bus_read(FACT_STATUS, v);  check("clear_status", v, 0);

    // Overrun while busy
    eng_mode = 0; eng_lat = 10;
    bus_write(FACT_N, 5);
    g0 = go_cnt;
    bus_write(FACT_CTRL, 1);
    bus_write(FACT_N, 7);
    bus_write(FACT_CTRL, 1);
    bus_read(FACT_STATUS, v);  check("ovr_busy", v, 32'h11);
    check("ovr_eng_n", eng_n, 5);
    bus_read(FACT_N, v);       check("ovr_n_kept", v, 5);
    repeat (9) @(negedge clk);
    bus_read(FACT_STATUS, v);  check("ovr_final", v, 32'h12);
    bus_read(FACT_RESULT, v);  check("ovr_result", v, 120);
    check("ovr_go_pulses", 32'(go_cnt - g0), 1);
    bus_write(FACT_CTRL, 32'h2);
    bus_read(FACT_STATUS, v);  check("ovr_cleared", v, 0);

    // Reset two cycles into WAIT
    eng_mode = 2;
    bus_write(FACT_N, 4);
    bus_write(FACT_CTRL, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    bus_read(FACT_STATUS, v);  check("midrst_status", v, 0);
    bus_read(FACT_RESULT, v);  check("midrst_result", v, 0);
    bus_read(FACT_N, v);       check("midrst_n", v, 0);
    check("midrst_go", {31'd0, eng_go}, 0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_txn(6, 0, 3, 1);

    // Randomized transactions
    for (int k = 0; k < 16; k++) begin
      int r, m;
      r = $urandom_range(0, 9);
      m = (r < 7) ? 0 : (r < 9) ? 1 : 2;
      run_txn($urandom_range(0, 15), m, $urandom_range(1, TO),
              32'h1 | ($urandom_range(0, 1) << 1) | ($urandom_range(0, 1) << 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
